spi_sram_responder: RTL
=======================

# spi_sram_responder

SPI-mode-0 target that emulates the serial SRAM our SPI controller talks to: READ (0x03) and WRITE (0x02) commands, a 24-bit address, then sequential data bytes until chip-select rises. It is backed by an internal byte array plus a host backdoor port. It serves as the on-chip/FPGA stand-in for the external SRAM and as the bench model for the controller. It oversamples the SPI pins with its own faster clock.

## Interface

Parameters:
- ADDR_WIDTH, 10, number of memory address bits (depth = 2^ADDR_WIDTH bytes).

Ports:
- clk_i  input  1  oversampling clock; one clock domain.
- rst_ni  input  1  asynchronous, active-low reset.
- sck  input  1  SPI clock from the initiator, asynchronous to clk_i.
- mosi  input  1  SPI data in, asynchronous.
- cs_n  input  1  SPI chip select, active-low, asynchronous.
- miso  output  1  SPI data out; plain driven output, 0 when not sending.
- busy_o  output  1  high while synchronized cs_n is low.
- err_o  output  1  one-cycle pulse when an unknown command byte completes.
- bd_we_i  input  1  backdoor write strobe.
- bd_adr_i  input  ADDR_WIDTH  backdoor address.
- bd_dat_i  input  8  backdoor write data.
- bd_dat_o  output  8  backdoor read data, one cycle after bd_adr_i is presented.

## Operation

- Synchronizers: sck, mosi and cs_n each pass through 2 flops. Rising/falling sck edges are detected from the synchronized value versus its delayed copy.
- Bit order: MSB first in every field. mosi is sampled on sck rising edges. miso is updated on sck falling edges.
- States: IDLE, CMD, ADDR, RDATA, WDATA, IGNORE.
- IDLE -> CMD when synchronized cs_n falls; bit counter cleared.
- CMD: shift 8 bits.
  - 0x03 -> ADDR (read).
  - 0x02 -> ADDR (write).
  - Any other value -> IGNORE, with an err_o pulse.
- ADDR: shift 24 bits. Only bits [ADDR_WIDTH-1:0] are kept; upper bits are ignored. On the 24th bit, go to RDATA or WDATA.
- RDATA:
  - On entry, a synchronous memory read of the current address is issued.
  - The result is loaded into the TX shift register on the next sck falling edge, which drives the MSB.
  - On each subsequent falling edge, shift left.
  - On the 8th rising edge of each byte, the address increments (wrapping from 2^ADDR_WIDTH-1 to 0) and the next byte is fetched. That byte's MSB goes out on the following falling edge.
- WDATA: shift 8 bits. On the 8th rising edge, write the byte to mem[addr] in the same cycle, then increment the address with the same wrap.
- IGNORE: hold until cs_n rises; miso stays 0; no memory access.
- Synchronized cs_n high in any state -> IDLE.
  - Bit counter cleared; miso forced to 0.
  - A partial write byte is discarded.
  - A partial read is simply abandoned.
- Backdoor:
  - bd_dat_o is always driven by a registered read of mem[bd_adr_i].
  - bd_we_i writes only when busy_o is low. While busy_o is high, bd_we_i is ignored; SPI owns the write port.
- Memory contents are not reset.

## Timing

- Reset values: miso 0, busy_o 0, err_o 0, bd_dat_o 0x00, state IDLE, address 0, shift registers 0.
- Pin-to-detection latency is 3 clk_i cycles (2 synchronizer flops plus edge detect).
- miso changes at most 4 clk_i cycles after the sck falling edge at the pin.
- Clock requirement: each sck phase is at least 4 clk_i cycles, i.e. clk_i is at least 8x the sck frequency. No other constraint.
- cs_n falling to the first sck rising edge must be at least 3 clk_i cycles.
- Write commit occurs 3 clk_i cycles after the 8th data rising edge at the pin. It is visible on bd_dat_o 1 cycle later.
- err_o pulses 3 clk_i cycles after the 8th command rising edge.
- busy_o follows cs_n with 2 cycles of latency.
- rst_ni assertion mid-transaction: all outputs take their reset values immediately (asynchronously). The next transaction after release decodes normally.
- Controller loopback: run the controller on a clock at most 1/4 of clk_i (its sck = controller clk/2).

## Test plan

- Backdoor write 0xA5 to 0x005, then SPI 0x03 + 0x000005 + 8 clocks -> initiator receives 0xA5, miso 0 after cs_n rises.
- SPI 0x02 + 0x000010 + 0x11,0x22,0x33 -> backdoor reads 0x11,0x22,0x33 at 0x010..0x012; bd_we_i during the burst has no effect.
- Preload mem[0x3FF]=0x5A, mem[0x000]=0xC3; SPI read at 0xFFFFFF, 2 bytes -> 0x5A, 0xC3 (upper bits ignored, address wraps).
- Command 0x9F + 32 more clocks -> err_o one pulse, miso 0 throughout, memory unchanged.
- Write 0x02 + 0x000020, cs_n rises after 5 data bits -> mem[0x020] unchanged; an immediate following read of 0x020 returns the old value.
- rst_ni low mid-read at data bit 3 -> miso/busy_o 0 at once. After release, a full read of 0x005 returns 0xA5 (contents preserved). Then loopback with the SPI controller at clk_i/4: a single write and a single read of 0x000123 -> read ack data equals the written byte.

Source files
------------

// File: rtl/spi_sram_responder.sv
// SPI mode-0 target that emulates a serial SRAM. It accepts READ (0x03) and WRITE (0x02),
// then a 24-bit address, then sequential data bytes until chip-select rises.
// The SPI pins are oversampled by clk_i through two-flop synchronizers.
//
// Ports:
//   clk_i     oversampling clock
//   rst_ni    asynchronous active-low reset
//   sck       SPI clock in (async)
//   mosi      SPI data in (async)
//   cs_n      SPI chip select, active low (async)
//   miso      SPI data out, 0 when not sending
//   busy_o    synchronized chip select is asserted
//   err_o     one-cycle pulse on an unknown command byte
//   bd_we_i   backdoor write strobe (ignored while busy_o)
//   bd_adr_i  backdoor address
//   bd_dat_i  backdoor write data
//   bd_dat_o  backdoor registered read data
module spi_sram_responder #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  sck,
  input  logic                  mosi,
  input  logic                  cs_n,
  output logic                  miso,
  output logic                  busy_o,
  output logic                  err_o,
  input  logic                  bd_we_i,
  input  logic [ADDR_WIDTH-1:0] bd_adr_i,
  input  logic [7:0]            bd_dat_i,
  output logic [7:0]            bd_dat_o
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CMD    = 3'd1;
  localparam logic [2:0] ST_ADDR   = 3'd2;
  localparam logic [2:0] ST_RDATA  = 3'd3;
  localparam logic [2:0] ST_WDATA  = 3'd4;
  localparam logic [2:0] ST_IGNORE = 3'd5;

  logic [7:0] mem [Depth];
  logic [7:0] mem_rdata_q;

  logic sck_s1_q, sck_s2_q, sck_d_q;
  logic mosi_s1_q, mosi_s2_q;
  logic cs_s1_q, cs_s2_q;

  logic [2:0]            state_q, state_d;
  logic [4:0]            bit_cnt_q, bit_cnt_d;
  logic [6:0]            shift_q, shift_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            tx_q, tx_d;
  logic                  load_q, load_d;
  logic                  is_read_q, is_read_d;
  logic                  err_q, err_d;
  logic [7:0]            bd_dat_q;

  logic       sck_rise, sck_fall;
  logic [7:0] shift_in;
  logic       spi_we;

  assign sck_rise = sck_s2_q & ~sck_d_q;
  assign sck_fall = ~sck_s2_q & sck_d_q;
  // Completed byte as of the current rising edge.
  assign shift_in = {shift_q, mosi_s2_q};

  // tx_q is cleared whenever chip select is released and never loaded outside RDATA.
  assign miso     = tx_q[7];
  assign busy_o   = ~cs_s2_q;
  assign err_o    = err_q;
  assign bd_dat_o = bd_dat_q;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    addr_d    = addr_q;
    tx_d      = tx_q;
    load_d    = load_q;
    is_read_d = is_read_q;
    err_d     = 1'b0;
    spi_we    = 1'b0;
    if (cs_s2_q) begin
      // Deselect aborts whatever is in flight; a partial write byte is dropped.
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      shift_d   = '0;
      tx_d      = '0;
      load_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d   = ST_CMD;
          bit_cnt_d = '0;
          shift_d   = '0;
        end
        ST_CMD: begin
          if (sck_rise) begin
            shift_d   = shift_in[6:0];
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d = '0;
              if (shift_in == 8'h03) begin
                state_d   = ST_ADDR;
                is_read_d = 1'b1;
              end else if (shift_in == 8'h02) begin
                state_d   = ST_ADDR;
                is_read_d = 1'b0;
              end else begin
                state_d = ST_IGNORE;
                err_d   = 1'b1;
              end
            end
          end
        end
        ST_ADDR: begin
          if (sck_rise) begin
            // Upper address bits fall off the top of the register.
            addr_d    = {addr_q[ADDR_WIDTH-2:0], mosi_s2_q};
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd23) begin
              bit_cnt_d = '0;
              state_d   = is_read_q ? ST_RDATA : ST_WDATA;
              load_d    = is_read_q;
            end
          end
        end
        ST_RDATA: begin
          if (sck_rise) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d = '0;
              addr_d    = addr_q + 1'b1;
              load_d    = 1'b1;
            end
          end else if (sck_fall) begin
            // mem_rdata_q tracks addr_q one cycle behind, long before the falling edge.
            if (load_q) begin
              tx_d   = mem_rdata_q;
              load_d = 1'b0;
            end else begin
              tx_d = {tx_q[6:0], 1'b0};
            end
          end
        end
        ST_WDATA: begin
          if (sck_rise) begin
            shift_d   = shift_in[6:0];
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d = '0;
              spi_we    = 1'b1;
              addr_d    = addr_q + 1'b1;
            end
          end
        end
        ST_IGNORE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sck_s1_q  <= 1'b0;
      sck_s2_q  <= 1'b0;
      sck_d_q   <= 1'b0;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
      cs_s1_q   <= 1'b1;
      cs_s2_q   <= 1'b1;
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      addr_q    <= '0;
      tx_q      <= '0;
      load_q    <= 1'b0;
      is_read_q <= 1'b0;
      err_q     <= 1'b0;
      bd_dat_q  <= '0;
    end else begin
      sck_s1_q  <= sck;
      sck_s2_q  <= sck_s1_q;
      sck_d_q   <= sck_s2_q;
      mosi_s1_q <= mosi;
      mosi_s2_q <= mosi_s1_q;
      cs_s1_q   <= cs_n;
      cs_s2_q   <= cs_s1_q;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      addr_q    <= addr_d;
      tx_q      <= tx_d;
      load_q    <= load_d;
      is_read_q <= is_read_d;
      err_q     <= err_d;
      bd_dat_q  <= mem[bd_adr_i];
    end
  end

  // Memory is deliberately not reset. SPI owns the write port while selected.
  always_ff @(posedge clk_i) begin
    if (spi_we) begin
      mem[addr_q] <= shift_in;
    end else if (bd_we_i && cs_s2_q) begin
      mem[bd_adr_i] <= bd_dat_i;
    end
    mem_rdata_q <= mem[addr_q];
  end

endmodule
